fir_mac_sched: RTL and testbench
================================

Name: fir_mac_sched

Overview:
Time-multiplexed FIR engine controller. It runs an (N+1)-tap direct-form FIR using a single multiply-accumulate unit, stepping through the taps under a small FSM. Input samples arrive on a valid/ready stream and results leave on a valid/ready stream. Coefficients come from a runtime configuration port with shadow/active banking. It replaces the fully parallel filter wherever area matters more than throughput.

Parameters:
N, 3, filter order; tap count is N+1.
WIDTH_X, 4, signed input sample width.
WIDTH_B, 4, signed coefficient width.
B, {1,2,3,4}, reset value of coefficient bank, N+1 entries of WIDTH_B bits; B[k] multiplies the sample k steps old.
WIDTH_Y (derived localparam), WIDTH_X+WIDTH_B+N+1, output width.

Ports:
clk  in  1  clock; all state updates on its rising edge.
rst  in  1  asynchronous, active-high reset.
s_valid  in  1  input sample valid.
s_ready  out  1  engine can accept a sample.
s_data  in  WIDTH_X  signed input sample.
m_valid  out  1  result valid.
m_ready  in  1  downstream accepts result.
m_data  out  WIDTH_Y  signed filter output.
cfg_we  in  1  coefficient write strobe.
cfg_addr  in  $clog2(N+1) (min 1)  tap index.
cfg_data  in  WIDTH_B  signed coefficient value.
busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, active-high) does the following:
  - FSM goes to IDLE.
  - Sample history z[0..N] is cleared to 0.
  - Shadow and active coefficient banks are loaded with B.
  - Accumulator and tap counter are cleared to 0.
  - Outputs: m_valid=0, m_data=0, s_ready=1, busy=0.
- FSM states are IDLE, MAC and OUT.
- IDLE:
  - s_ready=1.
  - On s_valid&&s_ready, the following happens at the same edge:
    - z[0]<=s_data and z[k]<=z[k-1] for k=1..N.
    - Active bank <= shadow bank.
    - acc<=0, k<=0, go to MAC.
- MAC:
  - s_ready=0.
  - Each cycle: acc<=acc+sext(z[k]*b_active[k]) and k<=k+1.
  - After the k==N step, go to OUT and load m_data with the final sum.
  - Exactly N+1 MAC cycles per sample.
- OUT:
  - m_valid=1 and m_data is held stable.
  - When m_ready=1, m_valid drops at the next edge and the FSM goes to IDLE.
  - m_data holds its last value after m_valid drops.
- Timing:
  - Latency: a sample accepted at edge t produces m_valid high after edge t+N+1.
  - Minimum sample period is N+3 cycles (IDLE, N+1 MAC cycles, 1 OUT cycle).
  - No accept is allowed in the same cycle as an OUT handshake.
- Arithmetic:
  - Product is signed WIDTH_X×WIDTH_B and is sign-extended to WIDTH_Y.
  - The accumulator is WIDTH_Y bits and cannot overflow for any input.
  - y = Σ z[k]·b[k], with z[0] the newest sample.
- Configuration:
  - cfg_we writes shadow[cfg_addr] in any state, including during reset release.
  - The active bank is frozen from sample acceptance until the result completes.
  - A write in the same cycle as an acceptance lands in shadow only; it takes effect at the next sample.
  - cfg_addr > N is ignored.
- Reset asserted mid-MAC or mid-OUT:
  - The in-flight result is discarded; no m_valid pulse is produced.
  - History and coefficients return to their reset values.
- AXI-style stream rules:
  - s_ready does not depend combinationally on s_valid.
  - m_valid and m_data must not change while m_valid=1 && m_ready=0.
- Flow control: while the FSM is not in IDLE, s_valid is ignored and the sample is not consumed.

Test Plan:
- Impulse with default B and m_ready=1: s_data=1,0,0,0 → m_data=1,2,3,4; each m_valid rises 4 cycles after its accept edge; accepts are spaced 6 cycles apart.
- Saturating-negative step: s_data=-8 four times → m_data=-8,-24,-48,-80.
- Backpressure: hold m_ready=0 for 10 cycles after the first result → m_valid=1 and m_data unchanged throughout, s_ready=0, a pending s_valid is not consumed; release → handshake, then the next sample is accepted.
- Coefficient update during MAC: write cfg_addr=0, cfg_data=4'hF (-1) while sample x=2 computes → that result uses b0=1; next sample x=2 yields -2 + 2·2 (+ older terms), matching a model with b0=-1 applied only from the second sample.
- Reset mid-MAC: assert rst two cycles into MAC → m_valid=0, busy=0, s_ready=1 immediately; after release, impulse 1,0,0,0 → 1,2,3,4 (coefficients restored to B).
- Random soak: 500 random s_data with random s_valid/m_ready toggling plus occasional cfg writes → every m_data equals a reference model that latches the shadow bank at acceptance; no lost or duplicated results; out-of-range cfg_addr (N=2 build, addr 3) has no effect.

Source files
------------

// File: rtl/fir_mac_sched.sv
// Time-multiplexed (N+1)-tap direct-form FIR: one multiply-accumulate step per tap,
// valid/ready streams on both sides, shadow/active coefficient banks.
//   state | meaning
//   IDLE  | waiting for a sample; s_ready high
//   MAC   | one tap per cycle, k = 0..N
//   OUT   | result presented until m_ready
module fir_mac_sched #(
  parameter int N = 3,
  parameter int WIDTH_X = 4,
  parameter int WIDTH_B = 4,
  parameter logic [(N+1)*WIDTH_B-1:0] B = {4'd4, 4'd3, 4'd2, 4'd1},
  localparam int WIDTH_Y = WIDTH_X + WIDTH_B + N + 1,
  localparam int AW = (N > 0) ? $clog2(N + 1) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic signed [WIDTH_X-1:0] s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic signed [WIDTH_Y-1:0] m_data,
  input  logic                      cfg_we,
  input  logic [AW-1:0]             cfg_addr,
  input  logic signed [WIDTH_B-1:0] cfg_data,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  localparam logic [AW-1:0] K_LAST = AW'(N);
  localparam int WIDTH_P = WIDTH_X + WIDTH_B;

  state_t                    state;
  logic signed [WIDTH_X-1:0] z      [N+1];
  logic signed [WIDTH_B-1:0] shadow [N+1];
  logic signed [WIDTH_B-1:0] active [N+1];
  logic signed [WIDTH_Y-1:0] acc;
  logic signed [WIDTH_Y-1:0] sum;
  logic signed [WIDTH_P-1:0] prod;
  logic [AW-1:0]             k;
  logic                      cfg_hit;

  assign cfg_hit = cfg_we && ({1'b0, cfg_addr} <= (AW+1)'(N));
  assign prod    = z[k] * active[k];
  assign sum     = acc + {{(WIDTH_Y-WIDTH_P){prod[WIDTH_P-1]}}, prod};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      k       <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      s_ready <= 1'b1;
      busy    <= 1'b0;
      for (int i = 0; i <= N; i++) begin
        z[i]      <= '0;
        shadow[i] <= B[i*WIDTH_B +: WIDTH_B];
        active[i] <= B[i*WIDTH_B +: WIDTH_B];
      end
    end else begin
      // Shadow writes are independent of the FSM; the active bank only
      // picks them up at the next acceptance.
      if (cfg_hit)
        shadow[cfg_addr] <= cfg_data;

      case (state)
        IDLE: begin
          if (s_valid && s_ready) begin
            z[0] <= s_data;
            for (int i = 1; i <= N; i++)
              z[i] <= z[i-1];
            active  <= shadow;
            acc     <= '0;
            k       <= '0;
            s_ready <= 1'b0;
            busy    <= 1'b1;
            state   <= MAC;
          end
        end
        MAC: begin
          acc <= sum;
          if (k == K_LAST) begin
            k       <= '0;
            m_data  <= sum;
            m_valid <= 1'b1;
            state   <= OUT;
          end else begin
            k <= k + 1'b1;
          end
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          m_valid <= 1'b0;
          s_ready <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Bench for fir_mac_sched: directed vectors with hand-computed results feed a
// scoreboard queue; a negedge monitor pops and compares on every output handshake.
module tb_fir_mac_sched;
  localparam int N  = 3;
  localparam int WY = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic signed [3:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic signed [WY-1:0] m_data;
  logic              cfg_we;
  logic [1:0]        cfg_addr;
  logic signed [3:0] cfg_data;
  logic              busy;

  fir_mac_sched dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  bit use_model = 1'b0;
  int n_acc = 0;
  logic signed [3:0] mz  [4];
  logic signed [3:0] msh [4];
  int  model_y;
  bit  prev_stall = 1'b0;
  int  prev_md = 0;
  time acc_time;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: history plus shadow bank, latched at each observed accept.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mz[i]  = '0;
        msh[i] = 4'(i + 1);
      end
      exp_q.delete();
    end else begin
      if (s_valid && s_ready) begin
        for (int i = 3; i > 0; i--) mz[i] = mz[i-1];
        mz[0] = s_data;
        model_y = 0;
        for (int i = 0; i < 4; i++) model_y += int'(mz[i]) * int'(msh[i]);
        n_acc++;
        if (use_model) exp_q.push_back(model_y);
      end
      if (cfg_we && int'(cfg_addr) <= N) msh[cfg_addr] = cfg_data;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", int'(m_valid), 1);
        check("hold_data", int'(m_data), prev_md);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_result: got %0d expected none", m_data);
        end else begin
          check("m_data", int'(m_data), exp_q.pop_front());
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_md    = int'(m_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input int exp, input bit push,
                      input bit cw = 1'b0, input int ca = 0, input int cd = 0);
    int t;
    if (push) exp_q.push_back(exp);
    s_valid = 1'b1;
    s_data  = 4'(x);
    t = 0;
    while (!s_ready && t < 100) begin
      tick();
      t++;
    end
    if (!s_ready) check("accept_timeout", 0, 1);
    cfg_we   = cw;
    cfg_addr = 2'(ca);
    cfg_data = 4'(cd);
    @(posedge clk);
    acc_time = $time;
    #1;
    s_valid = 1'b0;
    cfg_we  = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 50) begin
      tick();
      n++;
      if (m_valid) break;
    end
    if (!m_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(s_ready && !m_valid && exp_q.size() == 0) && t < 300) begin
      tick();
      t++;
    end
    if (t >= 300) check("idle_timeout", 0, 1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int a_before;
    int start_acc;
    int cyc;
    time prev_t;
    int step_exp[4] = '{-8, -24, -48, -80};

    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_s_ready", int'(s_ready), 1);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    tick();

    // Impulse: latency and sample spacing
    for (int i = 0; i < 4; i++) begin
      prev_t = acc_time;
      send((i == 0) ? 1 : 0, i + 1, 1'b1);
      if (i > 0) check("accept_spacing_ns", int'(acc_time - prev_t), 60);
      wait_valid(lat);
      check("latency", lat, 4);
    end
    wait_idle();

    for (int i = 0; i < 4; i++) send(-8, step_exp[i], 1'b1);
    wait_idle();

    // Backpressure with a pending sample
    m_ready = 1'b0;
    send(1, -71, 1'b1);
    wait_valid(lat);
    s_valid = 1'b1;
    s_data  = 4'sd0;
    a_before = n_acc;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", int'(m_valid), 1);
      check("bp_data", int'(m_data), -71);
      check("bp_s_ready", int'(s_ready), 0);
    end
    check("bp_no_consume", n_acc, a_before);
    m_ready = 1'b1;
    send(0, -54, 1'b1);
    wait_idle();

    // Coefficient update during MAC, then a write coincident with acceptance
    send(0, -29, 1'b1);
    send(0, 4, 1'b1);
    send(0, 0, 1'b1);
    wait_idle();
    send(2, 2, 1'b1);
    tick();
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = -4'sd1;
    tick();
    cfg_we = 1'b0;
    send(2, 2, 1'b1);
    send(0, 10, 1'b1);
    send(1, 13, 1'b1, 1'b1, 1, 0);
    send(0, 8, 1'b1);
    wait_idle();

    // Reset two cycles into MAC
    send(1, 99, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_m_valid", int'(m_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_s_ready", int'(s_ready), 1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) send((i == 0) ? 1 : 0, i + 1, 1'b1);
    wait_idle();

    // Random soak against the reference model
    use_model = 1'b1;
    start_acc = n_acc;
    cyc = 0;
    while (n_acc - start_acc < 500 && cyc < 15000) begin
      tick();
      cyc++;
      s_valid  = 1'($urandom_range(0, 1));
      s_data   = 4'($urandom);
      m_ready  = ($urandom_range(0, 9) < 7);
      cfg_we   = ($urandom_range(0, 9) == 0);
      cfg_addr = 2'($urandom);
      cfg_data = 4'($urandom);
    end
    s_valid = 1'b0;
    cfg_we  = 1'b0;
    m_ready = 1'b1;
    wait_idle();
    check("soak_accepts", int'(n_acc - start_acc >= 500), 1);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
